pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID and ID/EX segment registers.
- Detects load-use hazards and inserts one bubble into ID/EX.
- On a taken jump resolved in EX, flushes IF/ID and ID/EX for a programmable number of cycles.
- Freezes the whole front end while data memory reports busy; keeps stall/flush performance counters.

Parameters:
REG_W, 4, register-index width (matches RR3 width)
FLUSH_CYCLES, 1, cycles if_id_flush stays asserted after a taken jump; legal range 1..7
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  clock; state and counters update on posedge
rst  in  1  synchronous, active-low reset
rs1_id  in  REG_W  source register 1 of the instruction in ID
rs1_used_id  in  1  instruction in ID reads rs1
rs2_id  in  REG_W  source register 2 of the instruction in ID
rs2_used_id  in  1  instruction in ID reads rs2
rd_ex  in  REG_W  destination register (RR3_out) of the ID/EX register
memread_ex  in  1  MemRead_out of the ID/EX register
regwrite_ex  in  1  RegWrite_out of the ID/EX register
jump_taken_ex  in  1  jump resolved taken in EX (JumpI, or a JumpCI/JumpCD whose condition holds)
mem_busy  in  1  data memory not ready; the pipeline must hold
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_en  out  1  ID/EX register load enable
id_ex_flush  out  1  ID/EX loads all-zero controls (bubble)
stall_count  out  CNT_W  cycles with pc_en=0 since reset, saturating
flush_count  out  CNT_W  taken jumps accepted since reset, saturating

Behaviour:
- States: RUN, FLUSH. State register and a 3-bit flush counter fcnt.
- Enable and flush outputs are combinational from state and inputs. They settle after posedge, ahead of the negedge capture in the segment registers.
- Reset (rst=0 at posedge):
  - state=RUN, fcnt=0, stall_count=0, flush_count=0.
  - While rst=0: pc_en, if_id_en, id_ex_en, if_id_flush and id_ex_flush are all 0.
- Priority, evaluated every cycle: mem_busy > jump_taken_ex > load-use > normal.
- mem_busy=1 (any state):
  - pc_en=if_id_en=id_ex_en=0; both flushes 0.
  - State and fcnt hold; stall_count increments.
  - A jump_taken_ex arriving together with mem_busy is not accepted. It stays asserted because ID/EX is frozen, and is taken the first cycle mem_busy=0.
- Load-use hazard: lu = memread_ex & regwrite_ex & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)). No register index is exempt.
- RUN, no mem_busy:
  - Jump taken:
    - pc_en=1 (loads target), if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1.
    - flush_count increments.
    - If FLUSH_CYCLES>1: next state=FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else lu=1:
    - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0; stall_count increments.
    - Exactly one bubble, since on the next cycle the load has left EX.
  - Else: all enables 1, flushes 0.
- FLUSH, no mem_busy:
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1; lu is ignored.
  - fcnt decrements; when fcnt reaches 1, next state=RUN.
  - jump_taken_ex=1 in FLUSH reloads fcnt=FLUSH_CYCLES-1 and increments flush_count (defensive case).
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-FLUSH or mid-stall returns to RUN on that posedge; no pending jump is retained.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all enables/flushes 0, counts 0. After rst=1 with no hazards -> pc_en=if_id_en=id_ex_en=1.
- Load-use: memread_ex=1, regwrite_ex=1, rd_ex=4'h5, rs2_id=4'h5, rs2_used_id=1 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. The same case with rs2_used_id=0 -> no stall.
- Jump with FLUSH_CYCLES=3: jump_taken_ex pulse -> if_id_flush=1 for 3 consecutive cycles, id_ex_flush=1 in those cycles, flush_count=1, then RUN.
- Jump under memory busy: jump_taken_ex=1 and mem_busy=1 for 4 cycles -> no flush, all enables 0, stall_count=4. On mem_busy=0 -> flush asserted that cycle.
- Jump and load-use together: jump_taken_ex=1 with an lu match -> flush behaviour only, pc_en=1, stall_count unchanged.
- Saturation, CNT_W=4: 20 load-use stalls -> stall_count holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/sequencing controller.
// The datapath side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] rs1_id;
    logic             rs1_used_id;
    logic [REG_W-1:0] rs2_id;
    logic             rs2_used_id;
    logic [REG_W-1:0] rd_ex;
    logic             memread_ex;
    logic             regwrite_ex;
    logic             jump_taken_ex;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_id, rs1_used_id, rs2_id, rs2_used_id, rd_ex,
        output memread_ex, regwrite_ex, jump_taken_ex, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  stall_count, flush_count
    );

    modport slave (
        input  rs1_id, rs1_used_id, rs2_id, rs2_used_id, rd_ex,
        input  memread_ex, regwrite_ex, jump_taken_ex, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and ID/EX sequencing: load-use bubble, jump flush window, memory-busy freeze,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    localparam logic [2:0]       FRELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX    = '1;

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, stall_inc, flush_inc;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        lu = bus.memread_ex & bus.regwrite_ex &
             ((bus.rs1_used_id & (bus.rs1_id == bus.rd_ex)) |
              (bus.rs2_used_id & (bus.rs2_id == bus.rd_ex)));
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;

        // A jump seen under mem_busy is left pending: ID/EX is frozen, so it re-presents.
        if (rst && bus.mem_busy) begin
            stall_inc = 1'b1;
        end else if (rst) begin
            unique case (state_q)
                RUN: begin
                    if (bus.jump_taken_ex) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FRELOAD;
                        end
                    end else if (lu) begin
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        id_ex_en = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    if (bus.jump_taken_ex) begin
                        fcnt_d    = FRELOAD;
                        flush_inc = 1'b1;
                    end else if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = (stall_inc && stall_cnt_q != CMAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != CMAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4).
// Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}.
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 4;
    localparam int CNT_W = 4;
    localparam logic [4:0] V_RUN   = 5'b11010;
    localparam logic [4:0] V_STALL = 5'b00011;
    localparam logic [4:0] V_FL    = 5'b11111;
    localparam logic [4:0] V_OFF   = 5'b00000;

    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nerr = 0;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    wire [4:0] ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush};

    task automatic idle();
        bus.rs1_id = '0; bus.rs1_used_id = 1'b0; bus.rs2_id = '0; bus.rs2_used_id = 1'b0;
        bus.rd_ex = '0; bus.memread_ex = 1'b0; bus.regwrite_ex = 1'b0;
        bus.jump_taken_ex = 1'b0; bus.mem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic used2);
        bus.memread_ex = 1'b1; bus.regwrite_ex = 1'b1; bus.rd_ex = 4'h5;
        bus.rs2_id = 4'h5; bus.rs2_used_id = used2;
        bus.rs1_id = 4'h3; bus.rs1_used_id = 1'b1;
    endtask

    // Inputs change just after negedge; combinational outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(); rst = 1'b0; idle();
        step(); rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            rst = 1'b0;
            {bus.rs1_id, bus.rs2_id, bus.rd_ex} = 12'($urandom);
            {bus.rs1_used_id, bus.rs2_used_id, bus.memread_ex, bus.regwrite_ex,
             bus.jump_taken_ex, bus.mem_busy} = 6'($urandom);
            #1;
            ncmp++;
            if (ctl !== V_OFF) begin nerr++; $display("FAIL reset_ctl%0d got=%b exp=%b", i, ctl, V_OFF); end
        end
        step(); rst = 1'b1; idle(); #1;
        ncmp++;
        if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin
            nerr++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL reset_release got=%b exp=%b", ctl, V_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(1'b1); #1;
        ncmp++;
        if (ctl !== V_STALL) begin nerr++; $display("FAIL lu_stall got=%b exp=%b", ctl, V_STALL); end
        step(); idle(); #1;  // load has left EX, bubble is now there
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL lu_after got=%b exp=%b", ctl, V_RUN); end
        ncmp++;
        if (bus.stall_count !== 4'd1) begin nerr++; $display("FAIL lu_count got=%0d exp=1", bus.stall_count); end
        set_lu(1'b0); #1;
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL lu_unused got=%b exp=%b", ctl, V_RUN); end
        bus.rs1_id = 4'h5; #1;  // rs1 path matches now
        ncmp++;
        if (ctl !== V_STALL) begin nerr++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, V_STALL); end
        step(); set_lu(1'b1); bus.regwrite_ex = 1'b0; #1;
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL lu_noregwr got=%b exp=%b", ctl, V_RUN); end
        step(); idle(); #1;
        ncmp++;
        if (bus.stall_count !== 4'd2) begin nerr++; $display("FAIL lu_count2 got=%0d exp=2", bus.stall_count); end
    endtask

    task automatic test_jump();
        do_reset();
        bus.jump_taken_ex = 1'b1; #1;
        ncmp++;
        if (ctl !== V_FL) begin nerr++; $display("FAIL jmp_c0 got=%b exp=%b", ctl, V_FL); end
        step(); idle(); #1;
        ncmp++;
        if (ctl !== V_FL) begin nerr++; $display("FAIL jmp_c1 got=%b exp=%b", ctl, V_FL); end
        ncmp++;
        if (bus.flush_count !== 4'd1) begin nerr++; $display("FAIL jmp_count got=%0d exp=1", bus.flush_count); end
        step(); set_lu(1'b1); #1;  // hazard must be ignored inside the flush window
        ncmp++;
        if (ctl !== V_FL) begin nerr++; $display("FAIL jmp_c2 got=%b exp=%b", ctl, V_FL); end
        step(); idle(); #1;
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL jmp_run got=%b exp=%b", ctl, V_RUN); end
        ncmp++;
        if (bus.stall_count !== 4'd0) begin nerr++; $display("FAIL jmp_nostall got=%0d exp=0", bus.stall_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.jump_taken_ex = 1'b1;
        step();           // FLUSH, fcnt=2; second jump reloads
        step(); idle();   // FLUSH, fcnt=2 again
        for (int i = 0; i < 2; i++) begin
            #1;
            ncmp++;
            if (ctl !== V_FL) begin nerr++; $display("FAIL b2b_fl%0d got=%b exp=%b", i, ctl, V_FL); end
            step();
        end
        #1;
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL b2b_run got=%b exp=%b", ctl, V_RUN); end
        ncmp++;
        if (bus.flush_count !== 4'd2) begin nerr++; $display("FAIL b2b_count got=%0d exp=2", bus.flush_count); end
    endtask

    task automatic test_busy_jump();
        do_reset();
        bus.jump_taken_ex = 1'b1; bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            ncmp++;
            if (ctl !== V_OFF) begin nerr++; $display("FAIL busy_c%0d got=%b exp=%b", i, ctl, V_OFF); end
            step();
        end
        bus.mem_busy = 1'b0; #1;
        ncmp++;
        if (ctl !== V_FL) begin nerr++; $display("FAIL busy_release got=%b exp=%b", ctl, V_FL); end
        ncmp++;
        if (bus.stall_count !== 4'd4 || bus.flush_count !== 4'd0) begin
            nerr++; $display("FAIL busy_counts got=%0d/%0d exp=4/0", bus.stall_count, bus.flush_count);
        end
        step(); idle(); bus.mem_busy = 1'b1; #1;  // busy freezes FLUSH state too
        ncmp++;
        if (ctl !== V_OFF) begin nerr++; $display("FAIL busy_inflush got=%b exp=%b", ctl, V_OFF); end
        step(); bus.mem_busy = 1'b0; #1;
        ncmp++;
        if (ctl !== V_FL || bus.flush_count !== 4'd1) begin
            nerr++; $display("FAIL busy_resume got=%b/%0d exp=%b/1", ctl, bus.flush_count, V_FL);
        end
        step(); step(); #1;
        ncmp++;
        if (ctl !== V_RUN) begin nerr++; $display("FAIL busy_end got=%b exp=%b", ctl, V_RUN); end
    endtask

    task automatic test_jump_lu();
        do_reset();
        set_lu(1'b1); bus.jump_taken_ex = 1'b1; #1;
        ncmp++;
        if (ctl !== V_FL) begin nerr++; $display("FAIL jlu_ctl got=%b exp=%b", ctl, V_FL); end
        step(); idle(); #1;
        ncmp++;
        if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd1) begin
            nerr++; $display("FAIL jlu_counts got=%0d/%0d exp=0/1", bus.stall_count, bus.flush_count);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bus.jump_taken_ex = 1'b1;
        step(); idle(); rst = 1'b0; #1;
        ncmp++;
        if (ctl !== V_OFF) begin nerr++; $display("FAIL rstfl_ctl got=%b exp=%b", ctl, V_OFF); end
        step(); rst = 1'b1; #1;
        ncmp++;
        if (ctl !== V_RUN || bus.flush_count !== 4'd0) begin
            nerr++; $display("FAIL rstfl_run got=%b/%0d exp=%b/0", ctl, bus.flush_count, V_RUN);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu(1'b1);
        for (int i = 0; i < 15; i++) step();
        #1;
        ncmp++;
        if (bus.stall_count !== 4'd15) begin nerr++; $display("FAIL sat_at15 got=%0d exp=15", bus.stall_count); end
        for (int i = 0; i < 5; i++) step();
        #1;
        ncmp++;
        if (bus.stall_count !== 4'd15) begin nerr++; $display("FAIL sat_hold got=%0d exp=15", bus.stall_count); end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_jump();
        test_back_to_back();
        test_busy_jump();
        test_jump_lu();
        test_reset_mid_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
